// File: rtl/mx_blk_align.sv
// mx_blk_align: collects one MX block of FP32 elements, finds the shared
// exponent (maximum effective exponent) and streams each element's sign and
// augmented mantissa right-aligned to that exponent. Single buffer: the block
// is filled completely, then drained completely, with no overlap.
module mx_blk_align #(
  parameter int BLK_SIZE = 32,
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int OUT_W    = 24
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [EXP_W+MAN_W:0]        i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_sign,
  output logic [OUT_W-1:0]            o_man,
  output logic [EXP_W-1:0]            o_shared_exp,
  output logic                        o_special,
  output logic [$clog2(BLK_SIZE)-1:0] o_idx,
  output logic                        o_last
);

  localparam int IDX_W = $clog2(BLK_SIZE);
  // Zero padding below the stored mantissa when OUT_W is wider than {hidden, man}.
  localparam int PAD   = OUT_W - MAN_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);
  // Infinities and NaNs saturate to the largest finite exponent.
  localparam logic [EXP_W-1:0] EXP_SAT  = {{(EXP_W-1){1'b1}}, 1'b0};

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] wr_cnt, rd_cnt;
  logic [EXP_W-1:0] max_exp;
  logic             acc, hsk;

  // Block buffer; holds pre-decoded elements so the drain path only shifts.
  logic             mem_sign [BLK_SIZE];
  logic [EXP_W-1:0] mem_eff  [BLK_SIZE];
  logic [OUT_W-1:0] mem_man  [BLK_SIZE];
  logic             mem_spc  [BLK_SIZE];

  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic [EXP_W-1:0] in_eff;
  logic [OUT_W-1:0] in_aug;
  logic             in_spc;

  logic [EXP_W-1:0] rd_eff;
  logic [OUT_W-1:0] rd_man;
  logic [EXP_W-1:0] shift_d;

  // Effective exponent: zero/denormal behave as exponent 1, all-ones saturates.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    if (e == '0)
      return EXP_W'(1);
    else if (e == '1)
      return EXP_SAT;
    else
      return e;
  endfunction

  // {hidden, man} left-aligned in OUT_W; all-ones exponent forces all-ones mantissa.
  function automatic logic [OUT_W-1:0] aug_man(input logic [EXP_W-1:0] e,
                                               input logic [MAN_W-1:0] m);
    logic [MAN_W:0] hm;
    if (e == '0)
      hm = {1'b0, m};
    else if (e == '1)
      hm = '1;
    else
      hm = {1'b1, m};
    return OUT_W'(hm) << PAD;
  endfunction

  // Right shift with truncation; shifting by OUT_W or more flushes to zero.
  function automatic logic [OUT_W-1:0] align_trunc(input logic [OUT_W-1:0] m,
                                                   input logic [EXP_W-1:0] d);
    if (32'(d) >= 32'(OUT_W))
      return '0;
    return m >> d;
  endfunction

  // Stage p0: decode the incoming element
  always_comb begin
    in_sign = i_data[EXP_W+MAN_W];
    in_exp  = i_data[EXP_W+MAN_W-1:MAN_W];
    in_man  = i_data[MAN_W-1:0];
    in_eff  = eff_exp(in_exp);
    in_aug  = aug_man(in_exp, in_man);
    in_spc  = (in_exp == '1);
  end

  assign acc = i_valid & o_ready;
  assign hsk = o_valid & i_ready;

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= S_FILL;
    else
      state <= state_nxt;
  end

  // FSM next state; handshake flags come straight from the state register
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      S_FILL: begin
        o_ready = 1'b1;
        if (acc && (wr_cnt == LAST_IDX))
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_valid = 1'b1;
        if (hsk && (rd_cnt == LAST_IDX))
          state_nxt = S_FILL;
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // Write/read counters and running maximum exponent
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      max_exp <= '0;
    end else begin
      if (acc) begin
        max_exp <= (in_eff > max_exp) ? in_eff : max_exp;
        wr_cnt  <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + 1'b1;
      end
      if (hsk) begin
        if (rd_cnt == LAST_IDX) begin
          rd_cnt  <= '0;
          max_exp <= '0;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: block buffer write, data only, never reset
  always_ff @(posedge i_clk) begin
    if (acc) begin
      mem_sign[wr_cnt] <= in_sign;
      mem_eff[wr_cnt]  <= in_eff;
      mem_man[wr_cnt]  <= in_aug;
      mem_spc[wr_cnt]  <= in_spc;
    end
  end

  // Stage p2: align the element under the read pointer to the shared exponent
  always_comb begin
    rd_eff       = mem_eff[rd_cnt];
    rd_man       = mem_man[rd_cnt];
    shift_d      = max_exp - rd_eff;
    o_sign       = o_valid & mem_sign[rd_cnt];
    o_special    = o_valid & mem_spc[rd_cnt];
    o_man        = o_valid ? align_trunc(rd_man, shift_d) : '0;
    o_shared_exp = o_valid ? max_exp : '0;
    o_idx        = rd_cnt;
    o_last       = o_valid & (rd_cnt == LAST_IDX);
  end

endmodule
